pixel_arbiter: RTL and testbench

PIXEL_ARBITER -- requirements
Module: pixel_arbiter

---
 rtl/pixel_arbiter_pkg.sv | 16 +
 rtl/pixel_arbiter_if.sv | 29 ++
 rtl/pixel_arbiter_rr_picker.sv | 27 ++
 rtl/pixel_arbiter.sv | 104 ++++++++++
 tb/tb_pixel_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pixel_arbiter_pkg.sv
// Shared graphics definitions for the pixel arbiter: screen geometry, grant
// timeout and FSM state encoding.
package pixel_arbiter_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int TIMEOUT  = 65535;
  localparam int GRANT_W  = 2;
  localparam int COORD_W  = 11;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/pixel_arbiter_if.sv
// Bundle between the drawer clients (master) and the arbiter (slave),
// including the VGA adapter side driven by the arbiter.
interface pixel_arbiter_if #(parameter int N_CLIENTS = 4);
  import pixel_arbiter_pkg::*;

  logic [N_CLIENTS-1:0]          req;
  logic [N_CLIENTS-1:0]          draw_done_in;
  logic [COLOUR_W*N_CLIENTS-1:0] colour_in;
  logic [COORD_W*N_CLIENTS-1:0]  x_in;
  logic [COORD_W*N_CLIENTS-1:0]  y_in;
  logic [N_CLIENTS-1:0]          draw_start_out;
  logic [COLOUR_W-1:0]           vga_colour;
  logic [7:0]                    vga_x;
  logic [6:0]                    vga_y;
  logic                          vga_plot;
  logic                          busy;
  logic [GRANT_W-1:0]            grant_id;
  logic                          timeout_err;

  modport master (
    output req, draw_done_in, colour_in, x_in, y_in,
    input  draw_start_out, vga_colour, vga_x, vga_y, vga_plot, busy, grant_id, timeout_err
  );

  modport slave (
    input  req, draw_done_in, colour_in, x_in, y_in,
    output draw_start_out, vga_colour, vga_x, vga_y, vga_plot, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/pixel_arbiter_rr_picker.sv
// Round-robin picker: first set request bit searching upward from last+1,
// wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] index,
  output logic          valid
);
  logic [2*N-1:0] rotated;

  // Doubling the vector lets a plain shift perform the wrap-around rotation.
  assign rotated = {req, req} >> (int'(last) + 1);

  always_comb begin
    index = last;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        index = IW'((int'(last) + 1 + k) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_arbiter.sv
// Arbitrates N pixel-stream drawers onto a single VGA adapter port with
// round-robin grants, registered pixel output and a per-grant timeout.
module pixel_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int SCREEN_W  = pixel_arbiter_pkg::SCREEN_W,
  parameter int SCREEN_H  = pixel_arbiter_pkg::SCREEN_H,
  parameter int TIMEOUT   = pixel_arbiter_pkg::TIMEOUT
) (
  input logic            clock,
  input logic            resetn,
  pixel_arbiter_if.slave bus
);
  import pixel_arbiter_pkg::*;

  state_t               state_reg;
  logic [GRANT_W-1:0]   grant_id_reg;
  logic [15:0]          cnt_reg;
  logic                 timeout_err_reg;
  logic                 busy_reg;
  logic                 vga_plot_reg;
  logic [N_CLIENTS-1:0] draw_start_reg;
  logic [COLOUR_W-1:0]  vga_colour_reg;
  logic [7:0]           vga_x_reg;
  logic [6:0]           vga_y_reg;

  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic [COLOUR_W-1:0]  colour_arr [N_CLIENTS];
  logic [COORD_W-1:0]   x_arr      [N_CLIENTS];
  logic [COORD_W-1:0]   y_arr      [N_CLIENTS];
  logic                 cur_done;
  logic                 cur_on_screen;

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
    assign colour_arr[gi] = bus.colour_in[COLOUR_W*gi +: COLOUR_W];
    assign x_arr[gi]      = bus.x_in[COORD_W*gi +: COORD_W];
    assign y_arr[gi]      = bus.y_in[COORD_W*gi +: COORD_W];
  end

  rr_picker #(.N(N_CLIENTS), .IW(GRANT_W)) u_picker (
    .req   (bus.req),
    .last  (grant_id_reg),
    .index (pick_idx),
    .valid (pick_valid)
  );

  assign cur_done      = bus.draw_done_in[grant_id_reg];
  // Full-width compares so wrapped coordinates never alias onto the screen.
  assign cur_on_screen = (x_arr[grant_id_reg] < COORD_W'(SCREEN_W)) &&
                         (y_arr[grant_id_reg] < COORD_W'(SCREEN_H));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      grant_id_reg    <= GRANT_W'(N_CLIENTS - 1);
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
      busy_reg        <= 1'b0;
      vga_plot_reg    <= 1'b0;
      draw_start_reg  <= '0;
      vga_colour_reg  <= '0;
      vga_x_reg       <= '0;
      vga_y_reg       <= '0;
    end else begin
      vga_plot_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg      <= DRAW;
            grant_id_reg   <= pick_idx;
            cnt_reg        <= '0;
            busy_reg       <= 1'b1;
            draw_start_reg <= N_CLIENTS'(1) << pick_idx;
          end
        end
        DRAW: begin
          vga_colour_reg <= colour_arr[grant_id_reg];
          vga_x_reg      <= x_arr[grant_id_reg][7:0];
          vga_y_reg      <= y_arr[grant_id_reg][6:0];
          vga_plot_reg   <= !cur_done && cur_on_screen;
          cnt_reg        <= cnt_reg + 16'd1;
          // Completion wins over a coincident timeout and leaves the flag clear.
          if (cur_done || (cnt_reg == 16'(TIMEOUT - 1))) begin
            state_reg      <= RELEASE;
            busy_reg       <= 1'b0;
            draw_start_reg <= '0;
            if (!cur_done) timeout_err_reg <= 1'b1;
          end
        end
        RELEASE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.draw_start_out = draw_start_reg;
  assign bus.vga_colour     = vga_colour_reg;
  assign bus.vga_x          = vga_x_reg;
  assign bus.vga_y          = vga_y_reg;
  assign bus.vga_plot       = vga_plot_reg;
  assign bus.busy           = busy_reg;
  assign bus.grant_id       = grant_id_reg;
  assign bus.timeout_err    = timeout_err_reg;
endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed self-checking bench for pixel_arbiter: reset, full-screen sweep,
// bounds, round-robin order, timeout, async reset and done/timeout collision.
module tb_pixel_arbiter;
  // Timeout shortened so both timeout scenarios stay short, yet still longer
  // than the 19200-cycle single-grant sweep.
  localparam int TB_TIMEOUT = 20000;

  logic clock;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  pixel_arbiter_if #(.N_CLIENTS(4)) bus ();

  pixel_arbiter #(
    .N_CLIENTS (4),
    .SCREEN_W  (160),
    .SCREEN_H  (120),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.req          = '0;
    bus.draw_done_in = '0;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    int          plots;
    int          t;
    int unsigned order [5];
    logic [3:0]  onehot;

    order = '{0, 1, 2, 3, 0};
    resetn           = 1'b1;
    bus.req          = '0;
    bus.draw_done_in = '0;
    bus.colour_in    = '0;
    bus.x_in         = '0;
    bus.y_in         = '0;
    #2;

    // Reset values
    apply_reset();
    chk("rst_draw_start", 32'(bus.draw_start_out), 32'h0);
    chk("rst_plot",       32'(bus.vga_plot),       32'h0);
    chk("rst_busy",       32'(bus.busy),           32'h0);
    chk("rst_grant_id",   32'(bus.grant_id),       32'd3);
    chk("rst_timeout",    32'(bus.timeout_err),    32'h0);
    chk("rst_vga_data",   32'({bus.vga_colour, bus.vga_x, bus.vga_y}), 32'h0);
    tick();
    chk("idle_no_req",    32'({bus.busy, bus.draw_start_out, bus.vga_plot}), 32'h0);
    $display("reset checked");

    // Full-screen sweep by client 0
    bus.req = 4'b0001;
    tick();
    chk("sweep_grant", 32'({bus.grant_id, bus.draw_start_out, bus.busy}), 32'({2'd0, 4'b0001, 1'b1}));
    plots = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        bus.x_in[10:0]     = 11'(x);
        bus.y_in[10:0]     = 11'(y);
        bus.colour_in[2:0] = 3'(x + y);
        tick();
        plots += int'(bus.vga_plot);
        chk("sweep_pixel", 32'({bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y}),
            32'({1'b1, 3'(x + y), 8'(x), 7'(y)}));
      end
    end
    chk("sweep_plot_count", 32'(plots), 32'd19200);
    $display("sweep done, %0d plots", plots);

    // Screen bounds, still client 0
    bus.x_in[10:0] = 11'd160; bus.y_in[10:0] = 11'd0;
    tick();
    chk("x160_plot", 32'(bus.vga_plot), 32'h0);
    bus.x_in[10:0] = 11'd159; bus.y_in[10:0] = 11'd119;
    tick();
    chk("corner_plot", 32'({bus.vga_plot, bus.vga_x, bus.vga_y}), 32'({1'b1, 8'd159, 7'd119}));
    bus.x_in[10:0] = 11'd0; bus.y_in[10:0] = 11'd120;
    tick();
    chk("y120_plot", 32'(bus.vga_plot), 32'h0);
    bus.x_in[10:0] = 11'd261; bus.y_in[10:0] = 11'd128;
    tick();
    chk("wide_coord_plot", 32'({bus.vga_plot, bus.vga_x, bus.vga_y}), 32'({1'b0, 8'd5, 7'd0}));
    bus.x_in[10:0] = 11'd3; bus.y_in[10:0] = 11'd3;
    bus.draw_done_in = 4'b0001;
    tick();
    chk("done_release", 32'({bus.draw_start_out, bus.busy, bus.vga_plot}), 32'h0);
    bus.draw_done_in = '0;
    bus.req          = '0;
    tick(2);
    chk("idle_after_release", 32'({bus.draw_start_out, bus.busy, bus.grant_id}), 32'({4'b0, 1'b0, 2'd0}));
    $display("bounds checked");

    // Round-robin with all four requesting
    apply_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (bus.draw_start_out == 4'b0 && t < 8) begin
        tick();
        t++;
      end
      onehot = 4'b0001 << order[i];
      chk("rr_grant_id", 32'(bus.grant_id), 32'(order[i]));
      chk("rr_onehot",   32'(bus.draw_start_out), 32'(onehot));
      $display("grant %0d -> client %0d", i, bus.grant_id);
      bus.draw_done_in = ~onehot;
      tick(9);
      chk("rr_no_preempt", 32'(bus.draw_start_out), 32'(onehot));
      bus.draw_done_in = onehot;
      tick();
      chk("rr_release_gap", 32'({bus.draw_start_out, bus.busy}), 32'h0);
      bus.draw_done_in = '0;
    end
    bus.req = '0;
    tick(2);

    // Timeout on a client that never finishes; client 1 waits meanwhile
    apply_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0010;
    chk("to_grant", 32'(bus.draw_start_out), 32'(4'b0001));
    tick(TB_TIMEOUT - 1);
    chk("to_before", 32'({bus.draw_start_out, bus.timeout_err}), 32'({4'b0001, 1'b0}));
    tick();
    chk("to_release", 32'({bus.draw_start_out, bus.timeout_err}), 32'({4'b0000, 1'b1}));
    tick(2);
    chk("to_next_grant", 32'({bus.grant_id, bus.draw_start_out, bus.timeout_err}),
        32'({2'd1, 4'b0010, 1'b1}));
    $display("timeout fired, next grant client %0d", bus.grant_id);
    bus.draw_done_in = 4'b0010;
    tick();
    bus.draw_done_in = '0;
    bus.req          = '0;
    tick(2);
    chk("to_sticky", 32'(bus.timeout_err), 32'h1);

    // Async reset in the middle of client 2's grant
    apply_reset();
    chk("rst_clears_timeout", 32'(bus.timeout_err), 32'h0);
    bus.colour_in[8:6] = 3'd5;
    bus.x_in[32:22]    = 11'd10;
    bus.y_in[32:22]    = 11'd20;
    bus.req            = 4'b0100;
    tick();
    chk("c2_grant", 32'({bus.grant_id, bus.draw_start_out}), 32'({2'd2, 4'b0100}));
    tick();
    chk("c2_pixel", 32'({bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y}),
        32'({1'b1, 3'd5, 8'd10, 7'd20}));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({bus.draw_start_out, bus.vga_plot, bus.busy, bus.grant_id, bus.vga_x}),
        32'({4'b0, 1'b0, 1'b0, 2'd3, 8'd0}));
    tick();
    chk("rst_held_no_plot", 32'({bus.vga_plot, bus.draw_start_out}), 32'h0);
    resetn = 1'b1;
    tick();
    chk("c2_regrant", 32'({bus.grant_id, bus.draw_start_out}), 32'({2'd2, 4'b0100}));
    $display("async reset recovered, client %0d granted", bus.grant_id);
    bus.draw_done_in = 4'b0100;
    tick();
    bus.draw_done_in = '0;
    bus.req          = '0;
    tick(2);

    // Done coinciding with the final timeout cycle
    apply_reset();
    bus.req = 4'b0001;
    tick();
    tick(TB_TIMEOUT - 1);
    bus.draw_done_in = 4'b0001;
    tick();
    chk("coincide_release", 32'({bus.draw_start_out, bus.busy}), 32'h0);
    chk("coincide_no_err",  32'(bus.timeout_err), 32'h0);
    bus.draw_done_in = '0;
    bus.req          = '0;
    tick(2);
    $display("done/timeout collision checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
